ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 18 +
 rtl/ram_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default geometry for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Requester identities, used both for ownership and for round-robin priority.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the priority holder.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    if (req == 2'b11) begin
      grant = (prio == OWNER_B) ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one external single-port RAM between requesters A and B; clears the RAM after reset
// and serves one access per IDLE -> ACCESS -> RESP pass.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_req,
  input  logic              b_wren,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_q,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   a_q_q, a_q_d;
  logic [DATA_W-1:0]   b_q_q, b_q_d;
  logic [DATA_W-1:0]   rsp;
  logic [1:0]          grant;

  rr_arb2 u_rr_arb2 (
    .req   ({b_req, a_req}),
    .prio  (prio_q),
    .grant (grant)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    wren_d      = wren_q;
    addr_d      = addr_q;
    data_d      = data_q;
    a_q_d       = a_q_q;
    b_q_d       = b_q_q;
    rsp         = wren_q ? data_q : ram_q;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    init_busy   = 1'b0;

    unique case (state_q)
      INIT: begin
        init_busy   = 1'b1;
        ram_wren    = 1'b1;
        ram_address = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (|grant) begin
          owner_d = grant[1] ? OWNER_B : OWNER_A;
          wren_d  = grant[1] ? b_wren : a_wren;
          addr_d  = grant[1] ? b_addr : a_addr;
          data_d  = grant[1] ? b_data : a_data;
          prio_d  = grant[1] ? OWNER_A : OWNER_B;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_wren    = wren_q;
        ram_address = addr_q;
        ram_data    = data_q;
        // Writes echo the new data back; reads take the RAM's asynchronous output.
        if (owner_q == OWNER_B) b_q_d = rsp;
        else                    a_q_d = rsp;
        state_d = RESP;
      end
      RESP: begin
        a_ack   = (owner_q == OWNER_A);
        b_ack   = (owner_q == OWNER_B);
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      prio_q  <= OWNER_A;
      a_q_q   <= '0;
      b_q_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      a_q_q   <= a_q_d;
      b_q_q   <= b_q_d;
    end
  end

  // NOTE: the latched command is only consumed after IDLE reloads it, so it needs no reset.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    wren_q  <= wren_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
  end

  assign a_q = a_q_q;
  assign b_q = b_q_q;

endmodule
